// File: rtl/axil_master_cmd.sv
// AXI4-Lite master: turns single-beat read/write commands into AXI4-Lite transactions, one in flight.
// Define AXIL_MASTER_ERRCNT_EN to build the saturating SLVERR/DECERR counter on err_count.
module axil_master_cmd #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [DATA_W-1:0] M_AXI_WDATA,
    output logic [STRB_W-1:0] M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    localparam int unsigned AlignW = $clog2(STRB_W);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StRsp
    } state_e;

    state_e            state_q;
    logic              cmd_ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              arvalid_q;
    logic              bready_q;
    logic              rready_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [1:0]        rsp_resp_q;

    logic [ADDR_W-1:0] cmd_addr_aligned;
    logic              aw_pend_d;
    logic              w_pend_d;

    always_comb begin
        cmd_addr_aligned = cmd_addr;
        cmd_addr_aligned[AlignW-1:0] = '0;
    end

    // AW and W retire independently; each stays pending until its own handshake.
    always_comb begin
        aw_pend_d = awvalid_q & ~M_AXI_AWREADY;
        w_pend_d  = wvalid_q & ~M_AXI_WREADY;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_aligned;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWrAddrData;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRdAddr;
                        end
                    end
                end
                StWrAddrData: begin
                    awvalid_q <= aw_pend_d;
                    wvalid_q  <= w_pend_d;
                    if (!aw_pend_d && !w_pend_d) begin
                        bready_q <= 1'b1;
                        state_q  <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (M_AXI_BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= M_AXI_BRESP;
                        state_q     <= StRsp;
                    end
                end
                StRdAddr: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (M_AXI_RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b0;
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef AXIL_MASTER_ERRCNT_EN
    logic [15:0] err_count_q;
    logic        err_hit;

    // resp[1] set means SLVERR or DECERR.
    always_comb begin
        err_hit = ((state_q == StWrResp) && M_AXI_BVALID && M_AXI_BRESP[1]) ||
                  ((state_q == StRdData) && M_AXI_RVALID && M_AXI_RRESP[1]);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            err_count_q <= '0;
        end else if (err_hit && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 16'h0000;
`endif

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master_cmd.sv
// Bench for axil_master_cmd: AXI-Lite slave stub, transaction-level response model and directed tests.
`timescale 1ns/1ps
module tb_axil_master_cmd;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_count;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b1;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b1;
    logic [1:0]  M_AXI_BRESP = '0;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b1;
    logic [31:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = '0;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    axil_master_cmd #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Slave stub knobs and observations
    int          aw_dly = 0;
    int          w_dly = 0;
    bit          b_hold = 0;
    logic [1:0]  plan_resp = 2'b00;
    bit [31:0]   slv_mem [bit [31:0]];
    int          aw_hs_cyc, w_hs_cyc, b_hs_cyc, ar_hs_cyc, r_hs_cyc;
    int          b_hs_count = 0;
    int          awv_cycles = 0;
    int          wv_cycles = 0;
    logic [31:0] got_awaddr, got_wdata, got_araddr;

    initial begin : slave
        logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, s_awv, s_wv;
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        logic [3:0]  s_wstrb;
        logic        p_aw, p_w, p_ar;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb, aw_strb;
        bit          aw_got, w_got, b_pend;
        int          aw_wait, w_wait, sc;
        logic [31:0] aw_a, w_d;
        p_aw = 0; p_w = 0; p_ar = 0; aw_got = 0; w_got = 0; b_pend = 0;
        aw_wait = 0; w_wait = 0;
        forever begin
            @(negedge ACLK);
            sc = cyc;
            if (ARESETn) begin
                // VALID may not drop before its handshake, and payload must hold.
                if (p_aw) begin
                    chk("awvalid_held", M_AXI_AWVALID, 1);
                    chk("awaddr_stable", M_AXI_AWADDR, p_awaddr);
                end
                if (p_w) begin
                    chk("wvalid_held", M_AXI_WVALID, 1);
                    chk("wdata_stable", M_AXI_WDATA, p_wdata);
                    chk("wstrb_stable", M_AXI_WSTRB, p_wstrb);
                end
                if (p_ar) begin
                    chk("arvalid_held", M_AXI_ARVALID, 1);
                    chk("araddr_stable", M_AXI_ARADDR, p_araddr);
                end
                if (M_AXI_AWVALID) awv_cycles++;
                if (M_AXI_WVALID) wv_cycles++;
            end
            s_awv = ARESETn && M_AXI_AWVALID;
            s_wv = ARESETn && M_AXI_WVALID;
            s_aw_hs = s_awv && M_AXI_AWREADY;
            s_w_hs = s_wv && M_AXI_WREADY;
            s_ar_hs = ARESETn && M_AXI_ARVALID && M_AXI_ARREADY;
            s_b_hs = ARESETn && M_AXI_BVALID && M_AXI_BREADY;
            s_r_hs = ARESETn && M_AXI_RVALID && M_AXI_RREADY;
            s_awaddr = M_AXI_AWADDR; s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB;
            s_araddr = M_AXI_ARADDR;
            p_aw = s_awv && !M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
            p_w = s_wv && !M_AXI_WREADY; p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
            p_ar = ARESETn && M_AXI_ARVALID && !M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
                aw_got = 0; w_got = 0; b_pend = 0; aw_wait = 0; w_wait = 0;
                p_aw = 0; p_w = 0; p_ar = 0;
            end else begin
                if (s_aw_hs) begin
                    aw_got = 1; aw_a = s_awaddr; got_awaddr = s_awaddr; aw_hs_cyc = sc; aw_wait = 0;
                end else if (s_awv) aw_wait++;
                if (s_w_hs) begin
                    w_got = 1; w_d = s_wdata; aw_strb = s_wstrb; got_wdata = s_wdata;
                    w_hs_cyc = sc; w_wait = 0;
                end else if (s_wv) w_wait++;
                if (aw_got && w_got) begin
                    slv_mem[aw_a] = merge(slv_mem.exists(aw_a) ? slv_mem[aw_a] : 32'h0, w_d, aw_strb);
                    aw_got = 0; w_got = 0; b_pend = 1;
                end
                if (s_b_hs) begin
                    M_AXI_BVALID = 0; b_hs_count++; b_hs_cyc = sc;
                end
                if (b_pend && !b_hold && !M_AXI_BVALID) begin
                    M_AXI_BVALID = 1; M_AXI_BRESP = plan_resp; b_pend = 0;
                end
                if (s_r_hs) begin
                    M_AXI_RVALID = 0; r_hs_cyc = sc;
                end
                if (s_ar_hs) begin
                    got_araddr = s_araddr; ar_hs_cyc = sc;
                    M_AXI_RVALID = 1;
                    M_AXI_RDATA = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : 32'h0;
                    M_AXI_RRESP = plan_resp;
                end
            end
            M_AXI_AWREADY = (aw_dly == 0) || (aw_wait >= aw_dly);
            M_AXI_WREADY = (w_dly == 0) || (w_wait >= w_dly);
        end
    end

    // Transaction-level model: expected responses queued at command acceptance.
    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;
    rsp_t        exp_q[$];
    bit [31:0]   mdl_mem [bit [31:0]];
    bit          busy = 0;
    bit          up = 0;
    bit          rsp_seen = 0;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_strb;
    int          mdl_err = 0;
    int          acc_cyc, rsp_first_cyc, rsp_hs_cyc;

    initial begin : model
        bit          acc, rhs, a_wr;
        logic [31:0] a_addr, a_data, al;
        logic [3:0]  a_strb;
        int          sc;
        rsp_t        e;
        forever begin
            @(negedge ACLK);
            sc = cyc;
            if (ARESETn && up) begin
                chk("cmd_ready", cmd_ready, !busy);
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        if (!rsp_seen) begin
                            rsp_seen = 1;
                            rsp_first_cyc = sc;
`ifdef AXIL_MASTER_ERRCNT_EN
                            if (exp_q[0].resp[1] && mdl_err < 65535) mdl_err++;
`endif
                        end
                        chk("rsp_write", rsp_write, exp_q[0].wr);
                        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                        chk("rsp_resp", rsp_resp, exp_q[0].resp);
                    end
                end
                chk("err_count", err_count, mdl_err);
                al = cur_addr - (cur_addr % 4);
                if (M_AXI_AWVALID) chk("awaddr", M_AXI_AWADDR, al);
                if (M_AXI_ARVALID) chk("araddr", M_AXI_ARADDR, al);
                if (M_AXI_WVALID) begin
                    chk("wdata", M_AXI_WDATA, cur_wdata);
                    chk("wstrb", M_AXI_WSTRB, cur_strb);
                end
            end
            acc = ARESETn && cmd_valid && cmd_ready;
            rhs = ARESETn && rsp_valid && rsp_ready;
            a_wr = cmd_write; a_addr = cmd_addr; a_data = cmd_wdata; a_strb = cmd_wstrb;
            @(posedge ACLK);
            if (!ARESETn) begin
                exp_q.delete(); busy = 0; up = 0; mdl_err = 0; rsp_seen = 0;
                continue;
            end
            up = 1;
            if (rhs) begin
                void'(exp_q.pop_front());
                busy = 0; rsp_hs_cyc = sc;
            end
            if (acc) begin
                busy = 1; acc_cyc = sc; rsp_seen = 0;
                cur_addr = a_addr; cur_wdata = a_data; cur_strb = a_strb;
                al = a_addr - (a_addr % 4);
                e.wr = a_wr; e.resp = plan_resp;
                if (a_wr) begin
                    mdl_mem[al] = merge(mdl_mem.exists(al) ? mdl_mem[al] : 32'h0, a_data, a_strb);
                    e.rdata = 32'h0;
                end else begin
                    e.rdata = mdl_mem.exists(al) ? mdl_mem[al] : 32'h0;
                end
                exp_q.push_back(e);
            end
        end
    end

    logic        last_wr;
    logic [31:0] last_rdata;
    logic [1:0]  last_resp;

    task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        bit ok;
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("cmd_accept_timeout", 0, 1);
        @(posedge ACLK); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) chk("rsp_timeout", 0, 1);
        last_wr = rsp_write; last_rdata = rsp_rdata; last_resp = rsp_resp;
        @(posedge ACLK); #1;
    endtask

    task automatic reset_outputs_chk();
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_awaddr", M_AXI_AWADDR, 0);
        chk("rst_wdata", M_AXI_WDATA, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] stall_rdata;
        bit          ok;
        int          exp_err;
        exp_err = 0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        reset_outputs_chk();
        @(posedge ACLK); #1;
        ARESETn = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // Zero-wait write: accept N, AW/W N+1, B N+2, rsp N+3
        do_cmd(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        wait_rsp();
        chk("wr_aw_latency", aw_hs_cyc - acc_cyc, 1);
        chk("wr_w_latency", w_hs_cyc - acc_cyc, 1);
        chk("wr_b_latency", b_hs_cyc - acc_cyc, 2);
        chk("wr_rsp_latency", rsp_first_cyc - acc_cyc, 3);
        chk("wr_awaddr_lit", got_awaddr, 32'h10);
        chk("wr_wdata_lit", got_wdata, 32'hDEAD_BEEF);
        chk("wr_rsp_write_lit", last_wr, 1);
        chk("wr_rsp_resp_lit", last_resp, 2'b00);

        // Read back
        do_cmd(0, 32'h0000_0010, 32'h0, 4'h0);
        wait_rsp();
        chk("rd_ar_latency", ar_hs_cyc - acc_cyc, 1);
        chk("rd_r_latency", r_hs_cyc - acc_cyc, 2);
        chk("rd_rsp_latency", rsp_first_cyc - acc_cyc, 3);
        chk("rd_rdata_lit", last_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_write_lit", last_wr, 0);
        chk("rd_rsp_resp_lit", last_resp, 2'b00);

        // WREADY 5 cycles late
        awv_cycles = 0; wv_cycles = 0; b_hs_count = 0; w_dly = 5;
        do_cmd(1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF);
        wait_rsp();
        w_dly = 0;
        chk("slow_w_awvalid_cycles", awv_cycles, 1);
        chk("slow_w_wvalid_cycles", wv_cycles, 6);
        chk("slow_w_b_count", b_hs_count, 1);
        chk("slow_w_rsp_latency", rsp_first_cyc - acc_cyc, 8);

        // Misaligned read with SLVERR
        plan_resp = 2'b10;
        do_cmd(0, 32'h0000_0013, 32'h0, 4'h0);
        wait_rsp();
        plan_resp = 2'b00;
`ifdef AXIL_MASTER_ERRCNT_EN
        exp_err = 1;
`endif
        chk("misaligned_araddr_lit", got_araddr, 32'h10);
        chk("slverr_resp_lit", last_resp, 2'b10);
        chk("slverr_rdata_lit", last_rdata, 32'hDEAD_BEEF);
        chk("slverr_err_count_lit", err_count, exp_err);

        // DECERR on a write passes through unmodified
        plan_resp = 2'b11;
        do_cmd(1, 32'h0000_0018, 32'h0BAD_0BAD, 4'hF);
        wait_rsp();
        plan_resp = 2'b00;
`ifdef AXIL_MASTER_ERRCNT_EN
        exp_err = 2;
`endif
        chk("decerr_resp_lit", last_resp, 2'b11);
        chk("decerr_err_count_lit", err_count, exp_err);

        // Response back-pressure with a pending command
        rsp_ready = 0;
        do_cmd(0, 32'h0000_0014, 32'h0, 4'h0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) chk("stall_rsp_timeout", 0, 1);
        stall_rdata = rsp_rdata;
        chk("stall_rdata_lit", stall_rdata, 32'hCAFE_F00D);
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h1122_3344;
        cmd_wstrb = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("stall_cmd_ready", cmd_ready, 0);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rdata_stable", rsp_rdata, stall_rdata);
        end
        @(posedge ACLK); #1;
        rsp_ready = 1;
        @(negedge ACLK);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("stall_accept_timeout", 0, 1);
        @(posedge ACLK); #1;
        cmd_valid = 0;
        chk("stall_accept_after_rsp", acc_cyc - rsp_hs_cyc, 1);
        wait_rsp();
        do_cmd(0, 32'h0000_0020, 32'h0, 4'h0);
        wait_rsp();
        chk("partial_strb_rdata_lit", last_rdata, 32'h0022_0044);

        // Reset while waiting for B
        b_hold = 1;
        do_cmd(1, 32'h0000_0024, 32'h55AA_55AA, 4'hF);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (M_AXI_BREADY) begin ok = 1; break; end
        end
        chk("reached_wr_resp", ok, 1);
        @(posedge ACLK); #1;
        ARESETn = 0;
        @(posedge ACLK);
        @(negedge ACLK);
        reset_outputs_chk();
        b_hold = 0;
        @(posedge ACLK); #1;
        ARESETn = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("cmd_ready_after_mid_reset", cmd_ready, 1);
        do_cmd(0, 32'h0000_0024, 32'h0, 4'h0);
        wait_rsp();
        chk("post_reset_rdata_lit", last_rdata, 32'h55AA_55AA);
        chk("post_reset_err_count", err_count, 0);

        repeat (3) @(posedge ACLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axil_master_cmd.md
Name: axil_master_cmd

Overview:
Parametrised AXI4-Lite master. Converts a single-beat user command stream (read/write) into AXI4-Lite transactions on the M_AXI_* interface, and returns a response stream.
Successor to the fixed 32-bit axi_lite_master: generalised ADDR_W/DATA_W, with a handshaked command/response front end.
Sits between control logic (sequencers, CPU bridge) and any AXI4-Lite slave, including the AXI VIP in simulation.

Parameters:
ADDR_W, 32, AXI address width (>=12)
DATA_W, 32, AXI data width; 32 or 64 only
STRB_W, DATA_W/8, write strobe width (derived, not overridable)

Ports:
ACLK  in  1  clock; all logic rising-edge
ARESETn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  STRB_W  write strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP copy
err_count  out  16  error counter (see Optional Feature)
M_AXI_AWADDR/AWVALID/AWREADY  out/out/in  ADDR_W/1/1  write address channel
M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DATA_W/STRB_W/1/1  write data channel
M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
M_AXI_ARADDR/ARVALID/ARREADY  out/out/in  ADDR_W/1/1  read address channel
M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DATA_W/2/1/1  read data channel

Behaviour:
- Reset (ARESETn=0 at a clock edge): state=IDLE. All VALID outputs, BREADY, RREADY, rsp_valid = 0. All address/data/strb/rsp_* registers = 0. cmd_ready=0 during reset, 1 in IDLE afterwards. Reset mid-transaction aborts immediately; no AXI state is retained.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1. On accept, latch cmd fields. Address low log2(STRB_W) bits are forced to 0 on AW/ARADDR. Write -> WR_ADDR_DATA; read -> RD_ADDR. One transaction in flight; no outstanding pipelining.
- WR_ADDR_DATA: AWVALID and WVALID both rise on the cycle after accept. Each drops independently on its own handshake. AW and W handshakes may occur in either order or in the same cycle. Stay until both are done -> WR_RESP. VALID is never withdrawn before its handshake; payload is stable while VALID=1.
- WR_RESP: BREADY=1. On BVALID: capture BRESP, rsp_write=1, rsp_rdata=0 -> RSP.
- RD_ADDR: ARVALID=1 from the cycle after accept until ARREADY -> RD_DATA.
- RD_DATA: RREADY=1. On RVALID: capture RDATA/RRESP, rsp_write=0 -> RSP.
- RSP: rsp_valid=1, fields stable until rsp_ready -> IDLE. cmd_ready rises the cycle after the rsp handshake.
- Minimum latency with zero-wait slave: accept at cycle N, AW/W handshake at N+1, B at N+2, rsp_valid at N+3. Read is the same: AR at N+1, R at N+2, rsp_valid at N+3.
- READY inputs arriving before VALID are ignored. BVALID/RVALID outside the WR_RESP/RD_DATA states are ignored (BREADY/RREADY=0).
- Response codes are passed through unmodified. SLVERR/DECERR do not stall the FSM.

Optional Feature:
Macro AXIL_MASTER_ERRCNT_EN.
- Defined: err_count is a 16-bit counter, reset to 0. It increments by 1 on every captured response whose resp[1]=1 (SLVERR or DECERR) and saturates at 16'hFFFF.
- Undefined: err_count is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Write addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF; slave ready immediately -> AWADDR=0x10, WDATA=0xDEADBEEF handshake at N+1; rsp_valid at N+3 with rsp_write=1, rsp_resp=00.
- Read addr 0x0000_0010 after that write, slave returns 0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_write=0, rsp_resp=00.
- Write with WREADY delayed 5 cycles after AWREADY -> AWVALID drops after 1 cycle; WVALID holds with stable WDATA for 6 cycles; exactly one BREADY handshake.
- Misaligned read addr 0x13 (DATA_W=32) -> ARADDR=0x10. Slave returns RRESP=10 -> rsp_resp=10; with AXIL_MASTER_ERRCNT_EN, err_count goes 0->1.
- rsp_ready held low 4 cycles with cmd_valid asserted -> cmd_ready stays 0, rsp fields stable; next command is accepted the cycle after the rsp handshake.
- ARESETn asserted in WR_RESP -> next cycle all VALID/READY=0, rsp_valid=0, err_count=0; after release, cmd_ready=1.
